// File: rtl/leaderboard_pkg.sv
// Shared types and constants for the leaderboard tracker: FSM states,
// the game-finished mode code and the seven-segment glyph table.
package leaderboard_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, INSERT, CONVERT} state_t;

   localparam logic [2:0] FINISH = 3'b101;

   // Active-high {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG7 [10] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111
   };

   function automatic logic [6:0] seg7_of(input logic [3:0] d);
      return (d > 4'd9) ? 7'b0000000 : SEG7[d];
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift-add-3 step per cycle for SCORE_W cycles.
// The result register is written on the final step, the same edge done is seen.
module bin2bcd_seq
#(
   parameter int SCORE_W = 8,
   parameter int DIGITS  = 3
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  clear,
   input  logic                  start,
   input  logic [SCORE_W-1:0]    bin,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);
   localparam int CW = $clog2(SCORE_W + 1);

   logic [SCORE_W-1:0]  shift_reg;
   logic [4*DIGITS-1:0] work_reg;
   logic [4*DIGITS-1:0] adj;
   logic [4*DIGITS-1:0] bcd_reg;
   logic [CW-1:0]       cnt_reg;
   logic                active_reg;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      assign adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5) ?
                              work_reg[4*gi +: 4] + 4'd3 : work_reg[4*gi +: 4];
   end

   assign done = active_reg && (cnt_reg == CW'(SCORE_W - 1));
   assign bcd  = bcd_reg;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         shift_reg  <= '0;
         work_reg   <= '0;
         bcd_reg    <= '0;
         cnt_reg    <= '0;
         active_reg <= 1'b0;
      end else if (clear) begin
         shift_reg  <= '0;
         work_reg   <= '0;
         bcd_reg    <= '0;
         cnt_reg    <= '0;
         active_reg <= 1'b0;
      end else begin
         if (active_reg) begin
            work_reg  <= {adj[4*DIGITS-2:0], shift_reg[SCORE_W-1]};
            shift_reg <= shift_reg << 1;
            cnt_reg   <= cnt_reg + CW'(1);
            if (done) begin
               bcd_reg    <= {adj[4*DIGITS-2:0], shift_reg[SCORE_W-1]};
               active_reg <= 1'b0;
            end
         end
         // A restart may coincide with the last step of the previous run
         if (start) begin
            shift_reg  <= bin;
            work_reg   <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/leaderboard_tracker.sv
// Sorted top-DEPTH score table with one insertion per entry into FINISH,
// rank reporting and a seven-segment view of any selected entry.
module leaderboard_tracker
   import leaderboard_pkg::*;
#(
   parameter int         SCORE_W = 8,
   parameter int         DEPTH   = 4,
   parameter int         DIGITS  = 3,
   parameter logic [2:0] FINISH  = leaderboard_pkg::FINISH
) (
   input  logic                         clk,
   input  logic                         n_rst,
   input  logic [SCORE_W-1:0]           score,
   input  logic [2:0]                   mode,
   input  logic                         clear,
   input  logic [$clog2(DEPTH)-1:0]     sel_rank,
   output logic [7*DIGITS-1:0]          ss_disp,
   output logic [$clog2(DEPTH+1)-1:0]   rank_out,
   output logic                         new_record,
   output logic                         busy
);
   localparam int IW = $clog2(DEPTH);
   localparam int RW = $clog2(DEPTH + 1);

   state_t              state_reg, state_next;
   logic [2:0]          mode_prev_reg;
   logic [IW-1:0]       sel_prev_reg, idx_reg, pos_reg;
   logic                found_reg;
   logic [SCORE_W-1:0]  score_reg, pend_score_reg;
   logic                pend_cap_reg, pend_ref_reg;
   logic [SCORE_W-1:0]  tbl_reg  [DEPTH];
   logic [SCORE_W-1:0]  tbl_next [DEPTH];
   logic [DEPTH-1:0]    valid_reg, valid_next;
   logic [RW-1:0]       rank_reg;
   logic                new_record_reg;

   logic trigger, leave_finish, sel_change, ready, take_pend, take_new;
   logic hit, ins, conv_start, conv_done;
   logic [SCORE_W-1:0]  operand;
   logic [4*DIGITS-1:0] bcd;

   assign trigger      = (mode == FINISH) && (mode_prev_reg != FINISH);
   assign leave_finish = (mode != FINISH) && (mode_prev_reg == FINISH);
   assign sel_change   = (sel_rank != sel_prev_reg);
   // ready: the FSM is free to pick its next job this cycle
   assign ready        = (state_reg == IDLE) || ((state_reg == CONVERT) && conv_done);
   assign take_pend    = ready && pend_cap_reg;
   assign take_new     = ready && !pend_cap_reg && trigger;
   assign hit          = !valid_reg[idx_reg] || (score_reg > tbl_reg[idx_reg]);
   assign ins          = (state_reg == INSERT) && found_reg;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
      logic [SCORE_W-1:0] above;
      logic               above_v;
      if (gi == 0) begin : g_top
         assign above   = '0;
         assign above_v = 1'b0;
      end else begin : g_rest
         assign above   = tbl_reg[gi-1];
         assign above_v = valid_reg[gi-1];
      end
      assign tbl_next[gi]   = (!ins || gi < int'(pos_reg)) ? tbl_reg[gi] :
                              (gi == int'(pos_reg)) ? score_reg : above;
      assign valid_next[gi] = (!ins || gi < int'(pos_reg)) ? valid_reg[gi] :
                              (gi == int'(pos_reg)) ? 1'b1 : above_v;
   end

   // Operand comes from the post-insert table so the new score is visible at once
   assign operand = valid_next[sel_rank] ? tbl_next[sel_rank] : '0;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (clear) begin
         state_next = IDLE;
      end else if (ready) begin
         if (take_pend || take_new)          state_next = SCAN;
         else if (pend_ref_reg || sel_change) state_next = CONVERT;
         else                                 state_next = IDLE;
      end else begin
         case (state_reg)
            SCAN:    if (idx_reg == IW'(DEPTH - 1)) state_next = INSERT;
            INSERT:  state_next = CONVERT;
            default: state_next = state_reg;
         endcase
      end
   end

   always_comb begin
      busy       = (state_reg != IDLE);
      conv_start = (state_next == CONVERT) && ((state_reg != CONVERT) || conv_done);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mode_prev_reg  <= '0;
         sel_prev_reg   <= '0;
         idx_reg        <= '0;
         pos_reg        <= '0;
         found_reg      <= 1'b0;
         score_reg      <= '0;
         pend_score_reg <= '0;
         pend_cap_reg   <= 1'b0;
         pend_ref_reg   <= 1'b0;
         for (int k = 0; k < DEPTH; k++) tbl_reg[k] <= '0;
         valid_reg      <= '0;
         rank_reg       <= '0;
         new_record_reg <= 1'b0;
      end else begin
         mode_prev_reg <= mode;
         sel_prev_reg  <= sel_rank;
         if (clear) begin
            for (int k = 0; k < DEPTH; k++) tbl_reg[k] <= '0;
            valid_reg      <= '0;
            idx_reg        <= '0;
            pend_cap_reg   <= 1'b0;
            pend_ref_reg   <= 1'b0;
            rank_reg       <= '0;
            new_record_reg <= 1'b0;
         end else begin
            for (int k = 0; k < DEPTH; k++) tbl_reg[k] <= tbl_next[k];
            valid_reg <= valid_next;
            if (state_reg == SCAN) begin
               idx_reg   <= (idx_reg == IW'(DEPTH - 1)) ? '0 : idx_reg + IW'(1);
               found_reg <= (idx_reg == '0) ? hit : (found_reg || hit);
               if (hit && ((idx_reg == '0) || !found_reg)) pos_reg <= idx_reg;
            end
            if (state_reg == INSERT) begin
               rank_reg       <= found_reg ? RW'(pos_reg) + RW'(1) : '0;
               new_record_reg <= found_reg && (pos_reg == '0);
            end else if (leave_finish) begin
               new_record_reg <= 1'b0;
            end
            if (take_pend)     score_reg <= pend_score_reg;
            else if (take_new) score_reg <= score;
            // Serving the pending slot frees it for a trigger arriving that same cycle
            if (take_pend) begin
               pend_cap_reg   <= trigger;
               pend_score_reg <= score;
            end else if (trigger && !ready && !pend_cap_reg) begin
               pend_cap_reg   <= 1'b1;
               pend_score_reg <= score;
            end
            if (ready && !take_pend && !take_new) pend_ref_reg <= 1'b0;
            else if (sel_change)                  pend_ref_reg <= 1'b1;
         end
      end
   end

   bin2bcd_seq #(
      .SCORE_W (SCORE_W),
      .DIGITS  (DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .n_rst (n_rst),
      .clear (clear),
      .start (conv_start),
      .bin   (operand),
      .done  (conv_done),
      .bcd   (bcd)
   );

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign ss_disp[7*gi +: 7] = seg7_of(bcd[4*gi +: 4]);
   end

   assign rank_out   = rank_reg;
   assign new_record = new_record_reg;

endmodule

// File: tb/tb_leaderboard_tracker.sv
// Directed bench for leaderboard_tracker: insertion ranking, latency,
// display refresh, pending events and clear.
module tb_leaderboard_tracker;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [7:0]  score;
   logic [2:0]  mode;
   logic        clear;
   logic [1:0]  sel_rank;
   logic [20:0] ss_disp;
   logic [2:0]  rank_out;
   logic        new_record;
   logic        busy;

   localparam logic [2:0] FIN = 3'b101;
   localparam logic [6:0] G [10] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111
   };

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   leaderboard_tracker dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .score      (score),
      .mode       (mode),
      .clear      (clear),
      .sel_rank   (sel_rank),
      .ss_disp    (ss_disp),
      .rank_out   (rank_out),
      .new_record (new_record),
      .busy       (busy)
   );

   function automatic logic [20:0] ss3(input int h, input int t, input int u);
      return {G[h], G[t], G[u]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Counts busy cycles until busy falls; bounded.
   task automatic wait_busy(input string tag, output int n);
      n = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (busy) n++;
         else if (n > 0) return;
      end
      checks++;
      errors++;
      $error("FAIL %s_timeout observed busy_cycles=%0d expected busy to fall", tag, n);
   endtask

   task automatic game(input string tag, input logic [7:0] s, input int exp_rank,
                       input logic exp_nr);
      int n;
      score = s;
      mode  = FIN;
      wait_busy(tag, n);
      check({tag, "_busy"}, n, 13);
      check({tag, "_rank"}, rank_out, exp_rank);
      check({tag, "_nr"}, new_record, exp_nr);
      mode = 3'd0;
      @(posedge clk); #1;
   endtask

   task automatic show(input string tag, input logic [1:0] sel, input logic [20:0] exp_ss);
      int n;
      sel_rank = sel;
      wait_busy(tag, n);
      check({tag, "_busy"}, n, 8);
      check({tag, "_ss"}, ss_disp, exp_ss);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   initial begin
      int n, n0, extra;
      n_rst = 1'b0; score = '0; mode = '0; clear = 1'b0; sel_rank = '0;
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("rst_ss", ss_disp, ss3(0, 0, 0));
      check("rst_busy", busy, 0);
      check("rst_rank", rank_out, 0);
      check("rst_nr", new_record, 0);

      // Single capture while FINISH is held
      score = 8'd200;
      mode  = FIN;
      wait_busy("hold", n);
      check("hold_busy", n, 13);
      check("hold_rank", rank_out, 1);
      check("hold_nr", new_record, 1);
      check("hold_ss", ss_disp, ss3(2, 0, 0));
      extra = 0;
      repeat (17) begin
         @(posedge clk); #1;
         if (busy) extra++;
      end
      check("one_capture", extra, 0);
      mode = 3'd0;
      check("nr_before", new_record, 1);
      @(posedge clk); #1;
      check("nr_after", new_record, 0);
      check("rank_hold", rank_out, 1);

      pulse_clear();
      check("clr_rank", rank_out, 0);

      // Sorted insertion with a tie
      game("g50", 8'd50, 1, 1'b1);
      game("g90", 8'd90, 1, 1'b1);
      game("g70", 8'd70, 2, 1'b0);
      game("g90b", 8'd90, 2, 1'b0);
      check("g90b_ss", ss_disp, ss3(0, 9, 0));
      show("sel1", 2'd1, ss3(0, 9, 0));
      show("sel2", 2'd2, ss3(0, 7, 0));
      show("sel3", 2'd3, ss3(0, 5, 0));

      // Full table: not placed, then a new best evicting the last entry
      game("g10", 8'd10, 0, 1'b0);
      check("g10_ss", ss_disp, ss3(0, 5, 0));
      game("g255", 8'd255, 1, 1'b1);
      check("g255_ss", ss_disp, ss3(0, 7, 0));
      show("sel0", 2'd0, ss3(2, 5, 5));

      // Clear during CONVERT
      score = 8'd123;
      mode  = FIN;
      repeat (7) @(posedge clk);
      #1;
      check("mid_busy", busy, 1);
      pulse_clear();
      check("cc_busy", busy, 0);
      check("cc_ss", ss_disp, ss3(0, 0, 0));
      check("cc_rank", rank_out, 0);
      check("cc_nr", new_record, 0);
      mode = 3'd0;
      show("cs1", 2'd1, ss3(0, 0, 0));
      show("cs2", 2'd2, ss3(0, 0, 0));
      show("cs3", 2'd3, ss3(0, 0, 0));
      show("cs0", 2'd0, ss3(0, 0, 0));

      // sel_rank change mid-SCAN queues one extra conversion
      game("g30", 8'd30, 1, 1'b1);
      game("g20", 8'd20, 2, 1'b0);
      score = 8'd40;
      mode  = FIN;
      n0 = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (busy) n0++;
      end
      sel_rank = 2'd2;
      wait_busy("pref", n);
      check("pref_busy", n0 + n, 21);
      check("pref_rank", rank_out, 1);
      check("pref_ss", ss_disp, ss3(0, 2, 0));
      mode = 3'd0;
      @(posedge clk); #1;

      // Trigger while busy is held and served right after
      score = 8'd60;
      mode  = FIN;
      n0 = 0;
      @(posedge clk); #1;
      if (busy) n0++;
      mode = 3'd0;
      @(posedge clk); #1;
      if (busy) n0++;
      score = 8'd5;
      mode  = FIN;
      wait_busy("pcap", n);
      check("pcap_busy", n0 + n, 26);
      check("pcap_rank", rank_out, 0);
      check("pcap_nr", new_record, 0);
      check("pcap_ss", ss_disp, ss3(0, 3, 0));
      mode = 3'd0;
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/leaderboard_tracker.md
Name: leaderboard_tracker

Overview:
Parametrised successor to the single high-score register. Keeps a sorted top-DEPTH table of game scores, inserts the score once per entry into FINISH, and reports the rank achieved. Converts any selected table entry to BCD with a sequential double-dabble and drives DIGITS seven-segment glyphs. Sits beside the game FSM and feeds the score display mux.

Parameters:
SCORE_W, 8, score width in bits.
DEPTH, 4, number of table entries (>=2).
DIGITS, 3, displayed decimal digits; must satisfy 10^DIGITS > 2^SCORE_W-1.
FINISH, 3'b101, mode encoding of the game-finished state.

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
score  in  SCORE_W  score of the game just played
mode  in  3  game FSM state
clear  in  1  synchronous wipe of the table
sel_rank  in  $clog2(DEPTH)  table index to display (0 = best)
ss_disp  out  7*DIGITS  segment glyphs; digit 0 (units) in bits [6:0]
rank_out  out  $clog2(DEPTH+1)  1-based rank of last insertion; 0 = not placed
new_record  out  1  last insertion took rank 1
busy  out  1  insertion or conversion in progress

Behaviour:
- Reset: table entries 0, valid bits 0, state IDLE, rank_out 0, new_record 0, busy 0, ss_disp = DIGITS copies of the '0' glyph 7'b0111111.
- Capture trigger: rising edge of (mode==FINISH), using a registered copy of the previous mode. Holding FINISH for many cycles gives exactly one capture. score is latched on the trigger cycle.
- FSM states: IDLE -> SCAN -> INSERT -> CONVERT -> IDLE. busy = (state != IDLE).
- SCAN: DEPTH cycles. Index i steps 0..DEPTH-1. pos is the first i where the entry is invalid or latched score > entry (strict). Ties therefore rank below existing equal scores.
- INSERT: 1 cycle.
  - If pos was found: entries pos..DEPTH-2 shift down one place, the last entry drops, the score is written at pos with valid=1, rank_out=pos+1, new_record=(pos==0).
  - If pos was not found: the table is unchanged, rank_out=0, new_record=0.
- CONVERT: SCORE_W cycles of shift-add-3 on the operand table[sel_rank], which is latched on entry to CONVERT. ss_disp updates on the final cycle; invalid entries display as 0. Leading zeros are shown.
- Insertion latency: busy is high for exactly DEPTH+1+SCORE_W cycles starting the cycle after the trigger. rank_out, new_record and ss_disp are valid when busy falls.
- Display refresh: a sel_rank change while IDLE starts CONVERT directly (SCORE_W cycles; rank_out and new_record unchanged).
- Pending events:
  - A sel_rank change while busy sets a pending flag; after the current CONVERT completes, one extra CONVERT runs with the current sel_rank.
  - A trigger while busy is held in a 1-deep pending-capture register (score latched). Further triggers while it is full are dropped.
  - After finishing, pending capture is served before pending refresh.
- new_record also clears when mode leaves FINISH. rank_out holds until the next insertion or clear.
- clear has priority in any state:
  - Next cycle: table and valid bits zeroed, pending flags dropped, state IDLE, rank_out 0, new_record 0, ss_disp all '0' glyphs.
  - A trigger coinciding with clear is discarded.
- Asserting n_rst mid-operation behaves exactly as the reset description above.

Decomposition:
- Package leaderboard_pkg holds:
  - the state enum {IDLE, SCAN, INSERT, CONVERT};
  - the FINISH constant;
  - a 10-entry SEG7 glyph constant array in active-high {g,f,e,d,c,b,a} order: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111.
- One sub-module: bin2bcd_seq. It is the sequential double-dabble with start/done and parameters SCORE_W and DIGITS, and is instantiated once.

Test Plan:
1. Reset, then idle 5 cycles -> ss_disp = 21'b0111111_0111111_0111111, busy 0, rank_out 0, new_record 0.
2. score=200, mode held FINISH 30 cycles -> one capture only. busy high exactly 13 cycles, then rank_out=1, new_record=1, ss_disp = {1011011,0111111,0111111}. new_record drops the cycle after mode leaves FINISH.
3. Games 50, 90, 70, 90 in sequence -> table 90,90,70,50; fourth insertion rank_out=2; sel_rank=1 shows 090.
4. Full table 90,90,70,50, then score 10 -> rank_out=0, table unchanged. Then 255 -> rank_out=1, 50 evicted, sel_rank=3 shows 070.
5. clear asserted during CONVERT -> next cycle busy 0, ss_disp 000, rank_out 0; all sel_rank values then show 000.
6. sel_rank changed 0->2 mid-SCAN -> after insertion completes, busy stays high 8 more cycles and ss_disp shows entry 2.
